// File: rtl/player_move_ctrl.sv
// player_move_ctrl
//   Player movement controller for the grid game. Turns held direction keys
//   into single steps on a fresh press plus timed auto-repeat while the key
//   stays held, and owns the player's registered map position.
//
// Ports
//   clk      in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   key      in  4  held keys {right, up, down, left}, already synchronised
//   enable   in  1  movement permitted (low in menus / game over)
//   respawn  in  1  one-cycle pulse, return to the start position
//   allow    in  4  legal-direction mask from the boundary checker
//   move     out 4  one-hot requested direction (combinational)
//   pos_x    out 4  registered player column
//   pos_y    out 4  registered player row
//   dir      out 4  one-hot direction of the last accepted or blocked press
//   step     out 1  pulse in the cycle a new position appears
//   bump     out 1  pulse when a fresh press is blocked by a wall
module player_move_ctrl #(
  parameter int MAP_WIDTH     = 16,
  parameter int MAP_HEIGHT    = 12,
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int HOLD_DELAY    = 30_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       enable,
  input  logic       respawn,
  input  logic [3:0] allow,
  output logic [3:0] move,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [3:0] dir,
  output logic       step,
  output logic       bump
);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} state_t;

  localparam logic [3:0] X_MAX   = 4'(MAP_WIDTH - 1);
  localparam logic [3:0] Y_MAX   = 4'(MAP_HEIGHT - 1);
  localparam logic [3:0] X_START = 4'(START_X);
  localparam logic [3:0] Y_START = 4'(START_Y);
  // The counter is checked for zero before it is decremented, so loading the
  // full delay puts HOLD_DELAY+1 (REPEAT_PERIOD+1) cycles between position
  // changes.
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_DELAY);
  localparam logic [31:0] REPEAT_LOAD = 32'(REPEAT_PERIOD);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  pos_x_q, pos_x_d;
  logic [3:0]  pos_y_q, pos_y_d;
  logic [3:0]  dir_q, dir_d;
  logic        step_q, step_d;
  logic        bump_q, bump_d;

  logic        hit;
  logic        room;
  logic        step_ok;
  logic [3:0]  next_x;
  logic [3:0]  next_y;

  // Priority pick: left > down > up > right.
  always_comb begin
    move = 4'b0000;
    if (enable) begin
      if (key[0])      move = 4'b0001;
      else if (key[1]) move = 4'b0010;
      else if (key[2]) move = 4'b0100;
      else if (key[3]) move = 4'b1000;
    end
  end

  assign hit = |(move & allow);

  // Map-edge guard: a step that would leave the map is dropped even when the
  // boundary checker claims it is legal.
  always_comb begin
    room   = 1'b0;
    next_x = pos_x_q;
    next_y = pos_y_q;
    if (move[0]) begin
      room   = (pos_x_q != 4'd0);
      next_x = pos_x_q - 4'd1;
    end else if (move[1]) begin
      room   = (pos_y_q < Y_MAX);
      next_y = pos_y_q + 4'd1;
    end else if (move[2]) begin
      room   = (pos_y_q != 4'd0);
      next_y = pos_y_q - 4'd1;
    end else if (move[3]) begin
      room   = (pos_x_q < X_MAX);
      next_x = pos_x_q + 4'd1;
    end
  end

  assign step_ok = hit & room;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    bump_d  = 1'b0;

    if (respawn) begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
      pos_x_d = X_START;
      pos_y_d = Y_START;
      dir_d   = 4'b0000;
    end else if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move != 4'b0000) begin
            dir_d   = move;
            cnt_d   = HOLD_LOAD;
            state_d = ST_HOLD;
            if (step_ok) begin
              pos_x_d = next_x;
              pos_y_d = next_y;
              step_d  = 1'b1;
            end else if (!hit) begin
              bump_d = 1'b1;
            end
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (move != dir_q) begin
            // Release or change of direction: drop back to IDLE so the new
            // key is treated as a fresh press next cycle.
            state_d = ST_IDLE;
          end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            // Auto-repeat: a blocked repeat is silent (no bump).
            if (step_ok) begin
              pos_x_d = next_x;
              pos_y_d = next_y;
              step_d  = 1'b1;
            end
            cnt_d   = REPEAT_LOAD;
            state_d = ST_REPEAT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      pos_x_q <= X_START;
      pos_y_q <= Y_START;
      dir_q   <= 4'b0000;
      step_q  <= 1'b0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      bump_q  <= bump_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign bump  = bump_q;

endmodule
